// File: rtl/discrete_pkg.sv
`default_nettype none
// ============================================================================
// discrete_pkg : shared types for the discrete-logic timer emulations | Rev 1.0
// ============================================================================
package discrete_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } astable_state_t;

endpackage
`default_nettype wire

// File: rtl/astable_555_var.sv
`default_nettype none
// ============================================================================
// astable_555_var : 555 astable emulation, tick-counted high/low phases | Rev 1.0
// ============================================================================
module astable_555_var
  import discrete_pkg::*;
#(
  parameter int BW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [BW-1:0] HIGH_COUNTS,
  input  logic [BW-1:0] LOW_COUNTS,
  input  logic          COUNT_EN,
  input  logic          RUN,
  output logic          OUT,
  output logic          TRG_N,
  output logic          PHASE_END,
  output logic [BW-1:0] CNT_OUT
);

  localparam logic [BW-1:0] CNT_ONE = BW'(1);

  astable_state_t state_q, state_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  h_q, h_d;
  logic [BW-1:0]  l_q, l_d;
  logic           trg_n_q, trg_n_d;

  logic [BW-1:0]  h_last;
  logic [BW-1:0]  l_last;
  logic           high_done;
  logic           low_done;

  // A programmed length of 0 behaves as 1, so the terminal count is never -1.
  always_comb begin
    h_last    = (h_q == '0) ? '0 : h_q - CNT_ONE;
    l_last    = (l_q == '0) ? '0 : l_q - CNT_ONE;
    high_done = (state_q == HIGH) && COUNT_EN && (cnt_q == h_last);
    low_done  = (state_q == LOW)  && COUNT_EN && (cnt_q == l_last);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    l_d     = l_q;
    trg_n_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (RUN) begin
          state_d = HIGH;
          cnt_d   = '0;
          h_d     = HIGH_COUNTS;
        end
      end
      HIGH: begin
        if (!RUN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (high_done) begin
          state_d = LOW;
          cnt_d   = '0;
          l_d     = LOW_COUNTS;
          trg_n_d = 1'b0;
        end else if (COUNT_EN) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (!RUN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (low_done) begin
          state_d = HIGH;
          cnt_d   = '0;
          h_d     = HIGH_COUNTS;
        end else if (COUNT_EN) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      trg_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      trg_n_q <= trg_n_d;
    end
  end

  assign OUT       = (state_q == HIGH);
  assign TRG_N     = trg_n_q;
  assign PHASE_END = RUN && low_done;
  assign CNT_OUT   = (state_q == IDLE) ? '0 : cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_astable_555_var.sv
`default_nettype none
// ============================================================================
// tb_astable_555_var : directed self-checking bench for astable_555_var | Rev 1.0
// ============================================================================
module tb_astable_555_var;

  logic        clk;
  logic        rst;
  logic [31:0] high_counts;
  logic [31:0] low_counts;
  logic        count_en;
  logic        run;
  logic        out;
  logic        trg_n;
  logic        phase_end;
  logic [31:0] cnt_out;

  int n_checks = 0;
  int n_errors = 0;

  astable_555_var #(.BW(32)) dut (
    .CLK        (clk),
    .RST        (rst),
    .HIGH_COUNTS(high_counts),
    .LOW_COUNTS (low_counts),
    .COUNT_EN   (count_en),
    .RUN        (run),
    .OUT        (out),
    .TRG_N      (trg_n),
    .PHASE_END  (phase_end),
    .CNT_OUT    (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Per-view expectations for the 3/2 oscillation, starting at the first HIGH view
  logic [4:0] basic_out = 5'b00111;
  logic [4:0] basic_trg = 5'b10111;
  logic [4:0] basic_pe  = 5'b10000;
  int         basic_cnt [5] = '{0, 1, 2, 0, 1};

  initial begin
    high_counts = 32'd3;
    low_counts  = 32'd2;
    count_en    = 1'b1;
    run         = 1'b0;
    rst         = 1'b0;

    // Reset state
    do_reset();
    check("rst_out",   {31'd0, out},       32'd0);
    check("rst_trg_n", {31'd0, trg_n},     32'd1);
    check("rst_cnt",   cnt_out,            32'd0);
    check("rst_pe",    {31'd0, phase_end}, 32'd0);

    // Basic 3/2 oscillation
    run = 1'b1;
    check("idle_out_before_run", {31'd0, out}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("basic_out[%0d]", i), {31'd0, out},       {31'd0, basic_out[i % 5]});
      check($sformatf("basic_trg[%0d]", i), {31'd0, trg_n},     {31'd0, basic_trg[i % 5]});
      check($sformatf("basic_pe[%0d]", i),  {31'd0, phase_end}, {31'd0, basic_pe[i % 5]});
      check($sformatf("basic_cnt[%0d]", i), cnt_out,            32'(basic_cnt[i % 5]));
      tick();
    end

    // Zero counts: toggle every cycle
    high_counts = 32'd0;
    low_counts  = 32'd0;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("zero_out[%0d]", i), {31'd0, out},       (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("zero_trg[%0d]", i), {31'd0, trg_n},     (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("zero_pe[%0d]", i),  {31'd0, phase_end}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("zero_cnt[%0d]", i), cnt_out,            32'd0);
      tick();
    end

    // Gated counting: enable on every third view, 2/2 lengths give 6/6 cycles
    high_counts = 32'd2;
    low_counts  = 32'd2;
    do_reset();
    run      = 1'b1;
    count_en = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) begin
      count_en = (i % 3 == 2);
      #1;
      check($sformatf("gate_out[%0d]", i), {31'd0, out},       ((i / 6) % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("gate_cnt[%0d]", i), cnt_out,            32'((i % 6) / 3));
      check($sformatf("gate_trg[%0d]", i), {31'd0, trg_n},     (i == 6) ? 32'd0 : 32'd1);
      check($sformatf("gate_pe[%0d]", i),  {31'd0, phase_end}, (i == 11) ? 32'd1 : 32'd0);
      tick();
    end
    count_en = 1'b1;

    // Mid-phase update of HIGH_COUNTS: current HIGH keeps 4, next HIGH is 1
    high_counts = 32'd4;
    low_counts  = 32'd4;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (i == 1) high_counts = 32'd1;
      check($sformatf("upd_out[%0d]", i), {31'd0, out},
            (i < 4 || i == 8 || i == 13) ? 32'd1 : 32'd0);
      tick();
    end

    // RUN drop on the final LOW tick: no PHASE_END, straight to idle, no pulse
    high_counts = 32'd2;
    low_counts  = 32'd2;
    do_reset();
    run = 1'b1;
    tick();
    tick();
    tick();
    check("drop_cnt_before", cnt_out, 32'd0);
    check("drop_trg_before", {31'd0, trg_n}, 32'd0);
    tick();
    check("drop_cnt_at", cnt_out, 32'd1);
    run = 1'b0;
    #1;
    check("drop_pe_gated", {31'd0, phase_end}, 32'd0);
    tick();
    check("drop_out",   {31'd0, out},   32'd0);
    check("drop_cnt",   cnt_out,        32'd0);
    check("drop_trg_n", {31'd0, trg_n}, 32'd1);
    tick();
    check("drop_hold_out", {31'd0, out}, 32'd0);

    // Reset on the final HIGH tick: no TRG_N pulse
    run = 1'b1;
    tick();
    tick();
    check("rsthi_out_before", {31'd0, out}, 32'd1);
    check("rsthi_cnt_before", cnt_out,      32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b0;
    check("rsthi_out",   {31'd0, out},   32'd0);
    check("rsthi_cnt",   cnt_out,        32'd0);
    check("rsthi_trg_n", {31'd0, trg_n}, 32'd1);

    // Re-assert RUN: a full 3-cycle HIGH phase
    high_counts = 32'd3;
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rerun_out[%0d]", i), {31'd0, out}, (i < 3) ? 32'd1 : 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
